// File: rtl/wb_write_ctrl_if.sv
// Write-back port bundle between the ALU/load-store result sources and wb_write_ctrl.
// The master modport is the write-back controller; slave is the pipeline/register-file side.
interface wb_write_ctrl_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          mem_valid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          alu_valid;
  logic [AW-1:0] alu_addr;
  logic [DW-1:0] alu_data;
  logic          stall;
  logic          write;
  logic [AW-1:0] waddr1;
  logic [DW-1:0] din;
  logic [AW-1:0] fwd_addr;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;

  modport master (
    input  mem_valid, mem_addr, mem_data,
    input  alu_valid, alu_addr, alu_data,
    input  fwd_addr,
    output stall, write, waddr1, din,
    output fwd_hit, fwd_data
  );

  modport slave (
    output mem_valid, mem_addr, mem_data,
    output alu_valid, alu_addr, alu_data,
    output fwd_addr,
    input  stall, write, waddr1, din,
    input  fwd_hit, fwd_data
  );
endinterface

// File: rtl/wb_write_ctrl.sv
// Serialises mem and ALU results in program order onto the single register-file write port.
// Define WB_FWD_EN to build the forwarding search over pending writes.
module wb_write_ctrl #(
  parameter int AW    = 5,
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  wb_write_ctrl_if.master bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  entry_t        fifo [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;

  logic          write_q;
  logic [AW-1:0] waddr_q;
  logic [DW-1:0] din_q;

  logic   stall;
  logic   mem_acc;
  logic   alu_acc;
  logic   queued;
  entry_t mem_e;
  entry_t alu_e;

  logic   drain_valid;
  entry_t drain_e;
  logic   push0_en;
  entry_t push0_e;
  logic   push1_en;
  entry_t push1_e;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign stall   = (count == CW'(DEPTH));
  assign queued  = (count != '0);
  assign mem_acc = bus.mem_valid && !stall;
  assign alu_acc = bus.alu_valid && !stall;
  assign mem_e   = '{addr: bus.mem_addr, data: bus.mem_data};
  assign alu_e   = '{addr: bus.alu_addr, data: bus.alu_data};

  // Oldest candidate drains; the rest are pushed mem before ALU.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    drain_valid = 1'b0;
    drain_e     = fifo[rd_ptr];
    push0_en    = 1'b0;
    push0_e     = mem_e;
    push1_en    = 1'b0;
    push1_e     = alu_e;
    if (queued) begin
      drain_valid = 1'b1;
      if (mem_acc) begin
        push0_en = 1'b1;
        push1_en = alu_acc;
      end else if (alu_acc) begin
        push0_en = 1'b1;
        push0_e  = alu_e;
      end
    end else if (mem_acc) begin
      drain_valid = 1'b1;
      drain_e     = mem_e;
      push0_en    = alu_acc;
      push0_e     = alu_e;
    end else if (alu_acc) begin
      drain_valid = 1'b1;
      drain_e     = alu_e;
    end
  end

  assign count_next = count + CW'(push0_en) + CW'(push1_en) - CW'(queued);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      write_q <= 1'b0;
      waddr_q <= '0;
      din_q   <= '0;
    end else begin
      count   <= count_next;
      write_q <= drain_valid;
      if (drain_valid) begin
        waddr_q <= drain_e.addr;
        din_q   <= drain_e.data;
      end
      if (queued)        rd_ptr <= ptr_inc(rd_ptr);
      if (push1_en)      wr_ptr <= ptr_inc(ptr_inc(wr_ptr));
      else if (push0_en) wr_ptr <= ptr_inc(wr_ptr);
    end
  end

  // NOTE: the queue storage has no reset; entries are only visible through count, which does reset.
  always_ff @(posedge clk) begin
    if (push0_en) fifo[wr_ptr]          <= push0_e;
    if (push1_en) fifo[ptr_inc(wr_ptr)] <= push1_e;
  end

  assign bus.stall  = stall;
  assign bus.write  = write_q;
  assign bus.waddr1 = waddr_q;
  assign bus.din    = din_q;

`ifdef WB_FWD_EN
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
  logic [PW-1:0] idx;

  // Scan oldest to youngest so the last match left standing is the youngest write.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = rd_ptr;
    if (write_q && waddr_q == bus.fwd_addr) begin
      fwd_hit  = 1'b1;
      fwd_data = din_q;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count && fifo[idx].addr == bus.fwd_addr) begin
        fwd_hit  = 1'b1;
        fwd_data = fifo[idx].data;
      end
      idx = ptr_inc(idx);
    end
  end

  assign bus.fwd_hit  = fwd_hit;
  assign bus.fwd_data = fwd_data;
`else
  assign bus.fwd_hit  = 1'b0;
  assign bus.fwd_data = '0;
`endif

endmodule

// File: tb/tb_wb_write_ctrl.sv
// Directed bench for wb_write_ctrl: reset, single/dual arrivals, back-pressure and forwarding.
// Forwarding expectations follow whether WB_FWD_EN is defined for the build.
module tb_wb_write_ctrl;

  localparam int AW = 5;
  localparam int DW = 32;
`ifdef WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  wb_write_ctrl_if #(.AW(AW), .DW(DW)) bus ();

  wb_write_ctrl #(.AW(AW), .DW(DW), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic mv, input logic [AW-1:0] ma, input logic [DW-1:0] md,
                       input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad);
    bus.mem_valid = mv;
    bus.mem_addr  = ma;
    bus.mem_data  = md;
    bus.alu_valid = av;
    bus.alu_addr  = aa;
    bus.alu_data  = ad;
  endtask

  task automatic check_write(input string tag, input logic w, input logic [AW-1:0] a,
                             input logic [DW-1:0] d);
    check({tag, "_write"}, bus.write, w);
    check({tag, "_waddr1"}, bus.waddr1, a);
    check({tag, "_din"}, bus.din, d);
  endtask

  task automatic check_fwd(input string tag, input logic [AW-1:0] a, input logic hit,
                           input logic [DW-1:0] d);
    bus.fwd_addr = a;
    #1;
    check({tag, "_hit"}, bus.fwd_hit, FWD ? hit : 1'b0);
    check({tag, "_data"}, bus.fwd_data, FWD ? d : '0);
  endtask

  initial begin
    bit exp_stall [11];
    int k;
    exp_stall = '{0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0};

    rst = 1'b1;
    bus.fwd_addr = '0;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;
    check_write("por", 0, 0, 0);
    check("por_stall", bus.stall, 0);
    check("por_fwd_hit", bus.fwd_hit, 0);
    check("por_fwd_data", bus.fwd_data, 0);

    // Fill three queue entries, then reset with arrivals still present.
    drive(1, 5'd1, 32'h51, 1, 5'd2, 32'h52);
    tick();
    tick();
    tick();
    check_write("fill", 1, 5'd1, 32'h51);
    rst = 1'b1;
    tick();
    check_write("rst_q", 0, 0, 0);
    check("rst_q_stall", bus.stall, 0);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_q_idle_write", bus.write, 0);
    end

    // Single ALU result into an empty queue.
    drive(0, 0, 0, 1, 5'd3, 32'hAA);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    check_write("single", 1, 5'd3, 32'hAA);
    tick();
    check_write("single_idle", 0, 5'd3, 32'hAA);

    // Dual arrival to the same register: mem value first, ALU value second.
    drive(1, 5'd5, 32'h11, 1, 5'd5, 32'h22);
    #1;
    check("dual_stall", bus.stall, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    check_write("dual_mem", 1, 5'd5, 32'h11);
    tick();
    check_write("dual_alu", 1, 5'd5, 32'h22);
    tick();
    check("dual_idle_write", bus.write, 0);

    // Build: output reg r7=1, queue r7=2 then r9=0x30.
    drive(1, 5'd1, 32'h10, 1, 5'd7, 32'h1);
    tick();
    drive(1, 5'd7, 32'h2, 1, 5'd9, 32'h30);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    check_write("fwd_out", 1, 5'd7, 32'h1);
    check_fwd("fwd_r7", 5'd7, 1, 32'h2);
    check_fwd("fwd_r9", 5'd9, 1, 32'h30);
    check_fwd("fwd_r1", 5'd1, 0, 32'h0);
    bus.fwd_addr = 5'd8;
    #1;
    check("fwd_r8_hit", bus.fwd_hit, 0);
    bus.fwd_addr = 5'd7;
    tick();
    check_write("fwd_drain1", 1, 5'd7, 32'h2);
    check_fwd("fwd_r7_out", 5'd7, 1, 32'h2);
    tick();
    check_write("fwd_drain2", 1, 5'd9, 32'h30);
    check_fwd("fwd_r7_gone", 5'd7, 0, 32'h0);
    tick();
    check("fwd_idle_write", bus.write, 0);

    // Back-pressure: five dual pairs held until accepted; ten in-order writes.
    k = 0;
    for (int c = 0; c < 11; c++) begin
      if (k < 5)
        drive(1, AW'(10 + 2 * k), DW'(32'h100 + 2 * k), 1, AW'(11 + 2 * k), DW'(32'h101 + 2 * k));
      else
        drive(0, 0, 0, 0, 0, 0);
      #1;
      check("bp_stall", bus.stall, exp_stall[c]);
      if (!exp_stall[c] && k < 5) k++;
      tick();
      if (c < 10) check_write("bp", 1, AW'(10 + c), DW'(32'h100 + c));
      else        check("bp_idle_write", bus.write, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_write_ctrl.md
# wb_write_ctrl

Write-back initiator for the CPU's three-read/one-write register file. It accepts completed results from the ALU stage and the load/store stage, which can both arrive in the same cycle. It serialises them in program order onto the register file's single write port (`write`, `waddr1`, `din`). It back-pressures the pipeline when its pending queue cannot absorb another dual arrival.

## Interface
Parameters:
- `AW`, default 5: register address width.
- `DW`, default 32: register data width.
- `DEPTH`, default 4: pending-queue entries, excluding the output register; minimum 2.

Ports:
- `clk`, input, 1: clock; all state updates on the rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `mem_valid`, input, 1: load result present; older in program order than the ALU result of the same cycle.
- `mem_addr`, input, AW: destination register of the load result.
- `mem_data`, input, DW: load data.
- `alu_valid`, input, 1: ALU result present.
- `alu_addr`, input, AW: destination register of the ALU result.
- `alu_data`, input, DW: ALU data.
- `stall`, output, 1: high means no arrival is accepted this cycle; sources hold their valid and payload.
- `write`, output, 1: register-file write enable; registered.
- `waddr1`, output, AW: register-file write address; registered.
- `din`, output, DW: register-file write data; registered.
- `fwd_addr`, input, AW: forwarding lookup address.
- `fwd_hit`, output, 1: a pending write to `fwd_addr` exists.
- `fwd_data`, output, DW: data of the youngest pending write to `fwd_addr`.

## Operation
- Storage:
  - Circular FIFO of `DEPTH` entries, each holding {addr, data}.
  - Read pointer, write pointer, and a `count` register of width clog2(`DEPTH`+1).
  - One output register holding {`write`, `waddr1`, `din`}.
- Acceptance:
  - An arrival is accepted when its valid is high and `stall`=0.
  - `stall` is combinational: `stall` = (`count` == `DEPTH`).
- Ordering rule: the candidates each cycle, oldest first, are: FIFO entries (head first), then the accepted mem result, then the accepted ALU result.
- Drain: each cycle the oldest candidate is loaded into the output register and `write` is set to 1 the next cycle.
  - If there is no candidate, `write` is 0 next cycle and `waddr1`/`din` hold their previous values.
- Enqueue: candidates that are not drained and are not already in the FIFO are pushed in order.
  - The mem result is pushed before the ALU result.
- Count update:
  - n = number of accepted arrivals (0..2); p = 1 if (`count`+n) > 0, else 0.
  - `count` next = `count` + n − p.
  - The increment is at most +1, so with `stall` defined as above the FIFO never overflows.
- Same-cycle empty-queue case: with `count`=0 and both results valid, mem drains immediately and ALU enqueues; next cycle ALU drains.
- Same destination register: the two writes are issued in order, so the register file ends with the younger (ALU) value.
- Reset: when `rst`=1 at a clock edge:
  - `count`, both pointers, `write`, `waddr1` and `din` go to 0.
  - FIFO contents are discarded, including any mid-drain entries; in-flight arrivals that cycle are dropped.
  - `stall` reads 0 after reset.

## Timing
- Latency, arrival to `write`: 1 cycle when `count`=0 and the arrival is the oldest candidate; otherwise 1 + (number of older candidates) cycles.
- Throughput: one register-file write per cycle; sustained dual arrivals fill the FIFO at one entry per cycle.
- `stall` is high only while `count`=`DEPTH`. The cycle after a stall cycle, `count`=`DEPTH`−1 and `stall` drops, because a stall cycle has no arrivals and one drain.
- `write` is high for exactly one cycle per accepted result. There are no dropped or duplicated writes outside reset.
- Outputs after reset: `write`=0, `waddr1`=0, `din`=0, `stall`=0, `fwd_hit`=0, `fwd_data`=0.

## Configuration
- `WB_FWD_EN` defined:
  - `fwd_hit`/`fwd_data` are a combinational search of the output register (when `write`=1) and all valid FIFO entries.
  - The youngest match wins; FIFO tail is youngest, the output register is oldest.
  - This search does not see same-cycle arrivals.
- `WB_FWD_EN` undefined:
  - `fwd_hit`=0 and `fwd_data`=0 constantly; `fwd_addr` is unused.
  - No search logic is built.

## Test plan
- Reset with queue non-empty: fill 3 entries, assert `rst` 1 cycle → next cycle `write`=0, `waddr1`=0, `din`=0, `stall`=0, and no further writes issue.
- Single ALU result r3=0x0000_00AA with queue empty → next cycle `write`=1, `waddr1`=3, `din`=0xAA; the following cycle `write`=0.
- Dual arrival to the same register: mem r5=0x11 and ALU r5=0x22 in one cycle → writes r5=0x11 then r5=0x22 on consecutive cycles.
- Back-pressure with `DEPTH`=4 and dual arrivals every cycle: `stall` rises after 4 cycles; while it is high, held inputs are not accepted. All 10 results leave in program order, one per cycle, with no loss.
- Forwarding (`WB_FWD_EN`): queue holds r7=0x1 (older) and r7=0x2 (younger), `fwd_addr`=7 → `fwd_hit`=1, `fwd_data`=0x2. With `fwd_addr`=8 → `fwd_hit`=0.
- Forwarding compiled out: same stimulus → `fwd_hit`=0 and `fwd_data`=0 in all cycles.
